// File: rtl/horner_poly_top.sv
// Affine transform followed by four fixed-point Horner polynomial evaluations.
// Each frame is a header, 16 weights and a 3x4 matrix, then a stream of points.
// Every point produces one 4-lane Q8.8 result five cycles after it is accepted.
module horner_poly_top #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned WEIGHT_W   = 32,
    parameter int unsigned ACC_W      = 48
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_areset,
    input  logic [LANES*DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                        s00_axis_tvalid,
    output logic                        s00_axis_tready,
    input  logic                        s00_axis_tlast,
    output logic [LANES*OUT_WIDTH-1:0]  m00_axis_tdata,
    output logic                        m00_axis_tvalid,
    output logic                        m00_axis_tlast
);

    localparam int unsigned ROWS   = 3;
    localparam int unsigned NCOEF  = 4;
    localparam int unsigned NWGT   = LANES * NCOEF;
    localparam int unsigned FRAC   = 16;
    localparam int unsigned OSHIFT = 8;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned U_W    = PROD_W + 2;
    localparam int unsigned X_W    = U_W + 2;
    localparam int unsigned MUL_W  = ACC_W + X_W;
    localparam int unsigned SUM_W  = MUL_W + 1;

    typedef enum logic [1:0] {HDR, WGT, MAT, VEC} state_t;

    state_t                      state;
    logic [3:0]                  cnt;
    logic                        seen;
    logic [1:0]                  cal_num;
    logic signed [WEIGHT_W-1:0]  wgt [NWGT];
    logic signed [DATA_WIDTH-1:0] mat [ROWS][LANES];

    logic                        beat;
    logic                        pt_take;
    logic signed [DATA_WIDTH-1:0] lane_in [LANES];

    // Pipeline: stage 0 = products/coefficients, 1 = variables + acc=c3,
    // 2..4 = Horner steps, then the output register.
    logic                        vld [0:4];
    logic                        lst [0:4];
    logic signed [PROD_W-1:0]    prod_q [ROWS][LANES];
    logic signed [WEIGHT_W-1:0]  cf_q   [0:3][LANES][NCOEF];
    logic signed [X_W-1:0]       x_q    [1:3][LANES];
    logic signed [ACC_W-1:0]     acc_q  [1:4][LANES];

    logic signed [U_W-1:0]       u_c [ROWS];
    logic signed [X_W-1:0]       s_c;

    assign beat    = s00_axis_tvalid && s00_axis_tready;
    assign pt_take = beat && (state == VEC);

    // One Horner step: ((acc*x) >>> 16) + c, saturated to ACC_W.
    function automatic logic signed [ACC_W-1:0] horner_step(
        input logic signed [ACC_W-1:0]    acc,
        input logic signed [X_W-1:0]      x,
        input logic signed [WEIGHT_W-1:0] c
    );
        logic signed [MUL_W-1:0] prod;
        logic signed [SUM_W-1:0] sum;
        prod = MUL_W'(acc) * MUL_W'(x);
        sum  = SUM_W'(prod >>> FRAC) + SUM_W'(c);
        if (&sum[SUM_W-1:ACC_W-1] || ~|sum[SUM_W-1:ACC_W-1])
            return sum[ACC_W-1:0];
        else if (sum[SUM_W-1])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    // Q16 accumulator to saturated Q8.8 output lane.
    function automatic logic [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a >>> OSHIFT;
        if (&t[ACC_W-1:OUT_WIDTH-1] || ~|t[ACC_W-1:OUT_WIDTH-1])
            return t[OUT_WIDTH-1:0];
        else if (t[ACC_W-1])
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    // Split the input word into signed lanes.
    always_comb begin
        for (int c = 0; c < LANES; c++)
            lane_in[c] = s00_axis_tdata[DATA_WIDTH*c +: DATA_WIDTH];
    end

    // Row sums of the registered products and their total.
    always_comb begin
        logic signed [U_W-1:0] row;
        s_c = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = '0;
            for (int c = 0; c < LANES; c++)
                row = row + U_W'(prod_q[r][c]);
            u_c[r] = row;
            s_c    = s_c + X_W'(row);
        end
    end

    // Frame parser: header, weights, matrix, then points until tlast or a gap.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state           <= HDR;
            cnt             <= '0;
            seen            <= 1'b0;
            cal_num         <= '0;
            s00_axis_tready <= 1'b0;
            for (int i = 0; i < NWGT; i++)
                wgt[i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < LANES; c++)
                    mat[r][c] <= '0;
        end else begin
            s00_axis_tready <= 1'b1;
            case (state)
                HDR: if (beat) begin
                    cal_num <= (s00_axis_tdata[7:0] > 8'd3) ? 2'd3 : s00_axis_tdata[1:0];
                    cnt     <= '0;
                    state   <= WGT;
                end
                WGT: if (beat) begin
                    wgt[cnt] <= s00_axis_tdata[WEIGHT_W-1:0];
                    if (cnt == 4'(NWGT - 1)) begin
                        cnt   <= '0;
                        state <= MAT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                MAT: if (beat) begin
                    for (int c = 0; c < LANES; c++)
                        mat[cnt[1:0]][c] <= lane_in[c];
                    if (cnt == 4'(ROWS - 1)) begin
                        cnt   <= '0;
                        seen  <= 1'b0;
                        state <= VEC;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                VEC: begin
                    if (beat) begin
                        seen <= 1'b1;
                        if (s00_axis_tlast)
                            state <= HDR;
                    end else if (!s00_axis_tvalid && seen) begin
                        state <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    // Datapath registers; each stage carries its own copy of the coefficients.
    always_ff @(posedge s00_axis_aclk) begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LANES; c++)
                prod_q[r][c] <= PROD_W'(mat[r][c]) * PROD_W'(lane_in[c]);
        for (int j = 0; j < LANES; j++)
            for (int k = 0; k < NCOEF; k++)
                cf_q[0][j][k] <= (2'(k) <= cal_num) ? wgt[NCOEF*j + k] : '0;

        for (int r = 0; r < ROWS; r++)
            x_q[1][r] <= X_W'(u_c[r]);
        x_q[1][LANES-1] <= s_c;
        for (int j = 0; j < LANES; j++)
            acc_q[1][j] <= ACC_W'(cf_q[0][j][NCOEF-1]);

        for (int s = 1; s <= 3; s++)
            for (int j = 0; j < LANES; j++)
                for (int k = 0; k < NCOEF; k++)
                    cf_q[s][j][k] <= cf_q[s-1][j][k];
        for (int s = 2; s <= 3; s++)
            for (int j = 0; j < LANES; j++)
                x_q[s][j] <= x_q[s-1][j];
        for (int s = 2; s <= 4; s++)
            for (int j = 0; j < LANES; j++)
                acc_q[s][j] <= horner_step(acc_q[s-1][j], x_q[s-1][j], cf_q[s-1][j][4-s]);
    end

    // Valid/last shift register and the registered output word.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            for (int s = 0; s <= 4; s++) begin
                vld[s] <= 1'b0;
                lst[s] <= 1'b0;
            end
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
        end else begin
            vld[0] <= pt_take;
            lst[0] <= pt_take && s00_axis_tlast;
            for (int s = 1; s <= 4; s++) begin
                vld[s] <= vld[s-1];
                lst[s] <= lst[s-1];
            end
            m00_axis_tvalid <= vld[4];
            m00_axis_tlast  <= vld[4] && lst[4];
            if (vld[4]) begin
                for (int j = 0; j < LANES; j++)
                    m00_axis_tdata[OUT_WIDTH*j +: OUT_WIDTH] <= sat_out(acc_q[4][j]);
            end
        end
    end

endmodule

// File: tb/tb_horner_poly_top.sv
// Directed bench for horner_poly_top with hand-computed expected results.
module tb_horner_poly_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;

    horner_poly_top dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] q_data [$];
    logic        q_last [$];
    int unsigned q_cyc  [$];

    // Capture every output beat away from the active edge.
    always @(negedge clk) begin
        if (m_tvalid) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
            q_cyc.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wgt [16];
    logic [15:0] mat [3][4];
    int unsigned acc_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic beat(input logic [63:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) wgt[i] = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) mat[r][c] = '0;
    endtask

    task automatic load_cfg(input logic [7:0] cal);
        beat({56'd0, cal}, 1'b1);
        for (int i = 0; i < 16; i++) beat({32'd0, wgt[i]}, 1'b0);
        for (int r = 0; r < 3; r++) beat(pack(mat[r][0], mat[r][1], mat[r][2], mat[r][3]), 1'b0);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Compare output beat idx against data, last and the cycle it should appear in.
    task automatic check_out(input string tag, input int idx, input logic [63:0] d,
                             input logic l, input int unsigned oc);
        if (idx < q_data.size()) begin
            check({tag, "_data"}, q_data[idx], d);
            check({tag, "_last"}, 64'(q_last[idx]), 64'(l));
            check({tag, "_cyc"}, 64'(q_cyc[idx]), 64'(oc));
        end else begin
            check({tag, "_present"}, 64'(q_data.size()), 64'(idx + 1));
        end
    endtask

    task automatic one_point(input string tag, input logic [7:0] cal, input logic [63:0] v,
                             input logic l, input logic [63:0] exp);
        load_cfg(cal);
        clear_q();
        beat(v, l);
        acc_cyc = cyc;
        idle(10);
        check({tag, "_count"}, 64'(q_data.size()), 64'd1);
        check_out(tag, 0, exp, l, acc_cyc + 5);
    endtask

    // Runs one throughput frame of 14 back-to-back points followed by a gap.
    task automatic tput_frame(input int round);
        int v0, v1;
        load_cfg(8'd1);
        clear_q();
        for (int i = 0; i < 14; i++) begin
            v0 = i * 37 - 200;
            v1 = i * 5 - 30;
            beat(pack(16'(v0), 16'(v1), 16'(i), 16'd7), 1'b0);
            if (i == 0) acc_cyc = cyc;
        end
        idle(12);
        check($sformatf("tp%0d_count", round), 64'(q_data.size()), 64'd14);
        for (int i = 0; i < 14; i++) begin
            v0 = i * 37 - 200;
            v1 = i * 5 - 30;
            check_out($sformatf("tp%0d_%0d", round, i), i,
                      pack(16'(v0), 16'(2 * v1), 16'hFFFF, 16'(v0 + 2 * v1)), 1'b0, acc_cyc + 5 + i);
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        idle(3);

        // Reset state
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        rst = 1'b0;
        #1;
        check("release_tready_low", 64'(s_tready), 64'd0);
        idle(1);
        check("release_tready_high", 64'(s_tready), 64'd1);
        check("release_tvalid", 64'(m_tvalid), 64'd0);
        check("release_tdata", m_tdata, 64'd0);

        // Constant term in every lane: 1.0 -> 0x0100
        clear_cfg();
        wgt[0] = 32'd65536; wgt[4] = 32'd65536; wgt[8] = 32'd65536; wgt[12] = 32'd65536;
        one_point("const", 8'd0, pack(16'd1, 16'd2, 16'd3, 16'd1), 1'b0, 64'h0100_0100_0100_0100);

        // Quadratic: u0 = 2.0, x^2 = 4.0 -> 0x0400
        clear_cfg();
        wgt[2] = 32'd65536;
        mat[0][0] = 16'd512;
        one_point("quad", 8'd2, pack(16'd256, 16'd0, 16'd0, 16'd1), 1'b0, 64'h0000_0000_0000_0400);
        one_point("mask1", 8'd1, pack(16'd256, 16'd0, 16'd0, 16'd1), 1'b0, 64'h0000_0000_0000_0000);
        one_point("cal200", 8'd200, pack(16'd256, 16'd0, 16'd0, 16'd1), 1'b0, 64'h0000_0000_0000_0400);

        // Linear term with tlast: u0 = 32767/65536 -> 0x007F
        clear_cfg();
        wgt[1] = 32'd65536;
        mat[0][3] = 16'd32767;
        one_point("lin_last", 8'd1, pack(16'd0, 16'd0, 16'd0, 16'd1), 1'b1, 64'h0000_0000_0000_007F);

        // Positive then negative saturation, second point carries tlast
        clear_cfg();
        wgt[1] = 32'd65536;
        mat[0][0] = 16'd32767;
        load_cfg(8'd1);
        clear_q();
        beat(pack(16'd32767, 16'd0, 16'd0, 16'd0), 1'b0);
        acc_cyc = cyc;
        beat(pack(16'h8000, 16'd0, 16'd0, 16'd0), 1'b1);
        idle(10);
        check("sat_count", 64'(q_data.size()), 64'd2);
        check_out("sat_pos", 0, 64'h0000_0000_0000_7FFF, 1'b0, acc_cyc + 5);
        check_out("sat_neg", 1, 64'h0000_0000_0000_8000, 1'b1, acc_cyc + 6);

        // Throughput: lane0 = v0, lane1 = 2*v1, lane2 = floor(-1/256), lane3 = v0 + 2*v1
        clear_cfg();
        wgt[1] = 32'd65536; wgt[5] = 32'd65536; wgt[8] = 32'hFFFF_FFFF; wgt[13] = 32'd65536;
        mat[0][0] = 16'd256;
        mat[1][1] = 16'd512;
        tput_frame(1);
        tput_frame(2);

        // Reset while points are in flight drops them
        load_cfg(8'd1);
        clear_q();
        beat(pack(16'd10, 16'd1, 16'd0, 16'd0), 1'b0);
        beat(pack(16'd20, 16'd2, 16'd0, 16'd0), 1'b0);
        beat(pack(16'd30, 16'd3, 16'd0, 16'd0), 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_tready", 64'(s_tready), 64'd0);
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        idle(3);
        rst = 1'b0;
        idle(10);
        check("midrst_count", 64'(q_data.size()), 64'd0);
        check("midrst_tdata", m_tdata, 64'd0);

        // Recovery after reset
        clear_cfg();
        wgt[2] = 32'd65536;
        mat[0][0] = 16'd512;
        one_point("recover", 8'd2, pack(16'd256, 16'd0, 16'd0, 16'd1), 1'b0, 64'h0000_0000_0000_0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/horner_poly_top.md
Name: horner_poly_top

Overview:
- AXI-Stream compute block that evaluates fixed-point polynomials with Horner's method.
- Each frame carries a header, 16 polynomial weights and a 3x4 affine matrix, followed by a stream of 4-lane point vectors.
- For every point, the block applies the affine transform, evaluates four polynomials and emits one 4-lane result word.
- It sits between a DMA MM2S and S2MM stream, with no output backpressure.

Parameters:
- DATA_WIDTH, 16: width of each input lane (signed).
- OUT_WIDTH, 16: width of each output lane (signed Q8.8).
- LANES, 4: number of lanes. Fixed at 4; other values are unsupported.
- WEIGHT_W, 32: weight width (signed Q16.16), taken from tdata[WEIGHT_W-1:0].
- ACC_W, 48: width of the Horner accumulator (signed Q16).

Ports:
- s00_axis_aclk  in  1  the single clock for all logic.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_tdata  in  LANES*DATA_WIDTH  input word; lane k is bits [16k+15:16k].
- s00_axis_tvalid  in  1  input valid.
- s00_axis_tready  out  1  input ready.
- s00_axis_tlast  in  1  end-of-frame marker.
- m00_axis_tdata  out  LANES*OUT_WIDTH  result word.
- m00_axis_tvalid  out  1  result valid, one cycle per point.
- m00_axis_tlast  out  1  delayed copy of the tlast of the corresponding point.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM returns to HDR; all weights, matrix entries and CAL_NUM clear to 0.
  - All pipeline valid bits clear.
  - m00_axis_tdata=0, m00_axis_tvalid=0, m00_axis_tlast=0, s00_axis_tready=0.
  - A reset mid-frame drops all in-flight points.
- s00_axis_tready is 1 in every cycle outside reset. A beat transfers when tvalid is high (tready is always high).
- FSM, advancing on accepted beats:
  - HDR: CAL_NUM = min(tdata[7:0], 3). Go to WGT.
  - WGT: 16 beats load w[0..15] from tdata[31:0] (signed). Go to MAT.
  - MAT: 3 beats; beat r loads M[r][c] = lane c (signed Q16), c=0..3. Go to VEC.
  - VEC: each beat is a point v[0..3] (signed integer lanes).
  - VEC returns to HDR after accepting a beat with tlast=1, or in any cycle where tvalid=0 after at least one point has been accepted.
  - tlast is ignored in HDR, WGT and MAT.
- Transform, stage 1:
  - u_r = sum over c of M[r][c]*v[c], for r=0..2, in full precision (signed Q16, 34 bits).
  - s = u0+u1+u2.
- Polynomials:
  - Lane r (0..2) uses coefficients w[4r+k] with variable u_r.
  - Lane 3 uses coefficients w[12+k] with variable s.
  - Effective coefficient c_k = w[4j+k] if k <= CAL_NUM, else 0.
- Horner evaluation, three pipelined steps always:
  - acc starts at c3.
  - Each step: acc = ((acc*x) >>> 16) + c_{k}, for k = 2, 1, 0.
  - The product is taken at full width; >>> is an arithmetic shift (floor); c_k is sign-extended.
  - Each step's result saturates to signed ACC_W.
- Output: lane j = sat_OUT_WIDTH(acc_j >>> 8), i.e. signed Q8.8, clamped to 0x7FFF / 0x8000.
- Pipeline latency: 5 cycles from the accepting clock edge to the edge that asserts m00_axis_tvalid (transform, 3 Horner steps, output register).
  - Fully pipelined: one point per cycle, back-to-back points give back-to-back outputs.
  - m00_axis_tvalid is 0 in all other cycles.
- CAL_NUM, weights and matrix are sampled per point at stage 1. A new header arriving while earlier points are in flight does not corrupt those points.

Test Plan:
- Reset: hold reset, release -> tready=1 on the next cycle, m00_axis_tvalid=0 and tdata=0 throughout.
- Constant term: CAL_NUM=0, w0=w4=w8=w12=65536, other weights 0, identity-free M=0, one point (1,2,3,1) -> one output, data=0x0100_0100_0100_0100, 5 cycles after acceptance, tlast=0.
- Quadratic: CAL_NUM=2, w2=65536, M[0]=(512,0,0,0), point (256,0,0,1) -> u0=131072, lane0=0x0400; lanes 1..3 = 0.
- CAL_NUM masking: same as Quadratic but CAL_NUM=1 (w2 ignored) -> lane0=0x0000. CAL_NUM=200 behaves as 3.
- Saturation and tlast: CAL_NUM=1, w1=65536, M[0]=(0,0,0,32767), point with tlast=1 -> lane0 computed normally. Then M[0]=(32767,0,0,0), v0=32767 -> lane0=0x7FFF. m00_axis_tlast=1 with the tlast point's output.
- Throughput and re-frame: 14 back-to-back points, idle gap, then a second full frame -> 14 consecutive valid outputs, FSM back in HDR. The second frame's results are identical to the first. Reset asserted mid-VEC -> no further outputs.
